// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - Fibonacci LFSR random source with valid/ready output, seed loading and range rejection
//
// Optional build macro: LFSR_PERIOD_CHK_EN adds period_wrap / period_len period measurement outputs.
// LIMIT defaults to all-ones of WIDTH (31 at the default WIDTH of 5).

module lfsr_rng #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rand_out
`ifdef LFSR_PERIOD_CHK_EN
    ,
    output logic             period_wrap,
    output logic [31:0]      period_len
`endif
);

    typedef enum logic {
        GEN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_rand;
    logic             r_valid;

    logic             w_fb;
    logic [WIDTH-1:0] w_nxt;
    logic             w_step;
    logic             w_accept;
    logic [WIDTH-1:0] w_seed_val;
    logic             w_lockup;

    // Next-state feedback, handshake step enable and range test on the candidate value
    always_comb begin
        w_fb       = ^(r_lfsr & TAPS);
        w_nxt      = {r_lfsr[WIDTH-2:0], w_fb};
        w_step     = !r_valid || out_ready;
        w_accept   = (w_nxt != '0) && (w_nxt <= LIMIT);
        w_seed_val = (seed_in == '0) ? SEED : seed_in;
        w_lockup   = (r_lfsr == '0);
    end

    // GEN/HOLD state machine owning the LFSR state and the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GEN;
            r_lfsr  <= SEED;
            r_rand  <= '0;
            r_valid <= 1'b0;
        end else if (seed_load) begin
            // A transfer in this same cycle has already completed; the held value just goes invalid
            r_state <= GEN;
            r_lfsr  <= w_seed_val;
            r_valid <= 1'b0;
        end else if (w_lockup) begin
            r_state <= GEN;
            r_lfsr  <= SEED;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                GEN: begin
                    r_lfsr <= w_nxt;
                    if (w_accept) begin
                        r_rand  <= w_nxt;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_lfsr <= w_nxt;
                        if (w_accept) begin
                            r_rand <= w_nxt;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= GEN;
                        end
                    end
                end
                default: begin
                    r_state <= GEN;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign rand_out  = r_rand;

`ifdef LFSR_PERIOD_CHK_EN
    logic [WIDTH-1:0] r_seed_ref;
    logic [31:0]      r_count;
    logic             r_wrap;
    logic [31:0]      r_len;
    logic [31:0]      w_count_inc;

    // Saturating step count including the step being taken this cycle
    always_comb begin
        w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
    end

    // Track the last loaded seed and measure steps until the LFSR returns to it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed_ref <= SEED;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_len      <= '0;
        end else begin
            r_wrap <= 1'b0;
            if (seed_load) begin
                r_seed_ref <= w_seed_val;
                r_count    <= '0;
            end else if (w_lockup) begin
                r_seed_ref <= SEED;
                r_count    <= '0;
            end else if (w_step) begin
                if (w_nxt == r_seed_ref) begin
                    r_wrap  <= 1'b1;
                    r_len   <= w_count_inc;
                    r_count <= '0;
                end else begin
                    r_count <= w_count_inc;
                end
            end
        end
    end

    assign period_wrap = r_wrap;
    assign period_len  = r_len;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - directed self-checking bench for lfsr_rng

module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst;
    logic       seed_load;
    logic [4:0] seed_in;
    logic       out_ready;

    logic       a_valid;
    logic [4:0] a_rand;
    logic       b_valid;
    logic [4:0] b_rand;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef LFSR_PERIOD_CHK_EN
    logic        a_wrap;
    logic [31:0] a_len;
    logic        b_wrap;
    logic [31:0] b_len;
    logic        c_valid;
    logic [7:0]  c_rand;
    logic        c_wrap;
    logic [31:0] c_len;
`endif

    lfsr_rng dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(a_valid), .out_ready(out_ready), .rand_out(a_rand)
`ifdef LFSR_PERIOD_CHK_EN
        , .period_wrap(a_wrap), .period_len(a_len)
`endif
    );

    lfsr_rng #(.LIMIT(5'd20)) dut20 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(b_valid), .out_ready(out_ready), .rand_out(b_rand)
`ifdef LFSR_PERIOD_CHK_EN
        , .period_wrap(b_wrap), .period_len(b_len)
`endif
    );

`ifdef LFSR_PERIOD_CHK_EN
    lfsr_rng #(.WIDTH(8), .TAPS(8'b10111000), .SEED(8'd1), .LIMIT(8'd255)) dut8 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in({3'b000, seed_in}),
        .out_valid(c_valid), .out_ready(out_ready), .rand_out(c_rand),
        .period_wrap(c_wrap), .period_len(c_len)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] seq_a [8];
        logic [4:0] seq_b [8];
        logic       val_b [8];
        seq_a = '{5'd2, 5'd4, 5'd9, 5'd18, 5'd5, 5'd11, 5'd22, 5'd12};
        seq_b = '{5'd2, 5'd4, 5'd9, 5'd18, 5'd5, 5'd11, 5'd11, 5'd12};
        val_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; seed_load = 1'b0; seed_in = 5'd0; out_ready = 1'b1;
        tick();
        tick();
        check("reset_valid", {31'd0, a_valid}, 32'd0);
        check("reset_rand", {27'd0, a_rand}, 32'd0);

        // Default sequence and LIMIT=20 rejection side by side
        rst = 1'b0;
        check("first_cycle_valid", {31'd0, a_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("seq_valid[%0d]", i), {31'd0, a_valid}, 32'd1);
            check($sformatf("seq_rand[%0d]", i), {27'd0, a_rand}, {27'd0, seq_a[i]});
            check($sformatf("lim20_valid[%0d]", i), {31'd0, b_valid}, {31'd0, val_b[i]});
            check($sformatf("lim20_rand[%0d]", i), {27'd0, b_rand}, {27'd0, seq_b[i]});
        end

        // Stall while presenting 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("pre_stall_rand", {27'd0, a_rand}, 32'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_valid[%0d]", i), {31'd0, a_valid}, 32'd1);
            check($sformatf("stall_rand[%0d]", i), {27'd0, a_rand}, 32'd4);
        end
        out_ready = 1'b1;
        tick();
        check("post_stall_rand", {27'd0, a_rand}, 32'd9);

        // Seed load during a handshake
        seed_load = 1'b1; seed_in = 5'b01001;
        tick();
        seed_load = 1'b0;
        check("seed_valid", {31'd0, a_valid}, 32'd0);
        check("seed_rand_held", {27'd0, a_rand}, 32'd9);
        tick();
        check("seed_next_valid", {31'd0, a_valid}, 32'd1);
        check("seed_next_rand", {27'd0, a_rand}, 32'd18);
        seed_load = 1'b1; seed_in = 5'd0;
        tick();
        seed_load = 1'b0;
        check("seed0_valid", {31'd0, a_valid}, 32'd0);
        check("seed0_rand_held", {27'd0, a_rand}, 32'd18);
        tick();
        check("seed0_next_rand", {27'd0, a_rand}, 32'd2);

        // Reset in the middle of a stall
        out_ready = 1'b0;
        tick();
        check("midstall_rand", {27'd0, a_rand}, 32'd2);
        rst = 1'b1;
        tick();
        check("midstall_rst_valid", {31'd0, a_valid}, 32'd0);
        check("midstall_rst_rand", {27'd0, a_rand}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("restart_rand0", {27'd0, a_rand}, 32'd2);
        tick();
        check("restart_rand1", {27'd0, a_rand}, 32'd4);

`ifdef LFSR_PERIOD_CHK_EN
        begin
            int a_wraps;
            int c_wraps;
            logic [31:0] a_last;
            logic [31:0] c_last;
            a_wraps = 0; c_wraps = 0; a_last = 0; c_last = 0;
            rst = 1'b1;
            tick();
            check("period_rst_wrap", {31'd0, a_wrap}, 32'd0);
            check("period_rst_len", a_len, 32'd0);
            rst = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (a_wrap) begin a_wraps++; a_last = a_len; end
                if (c_wrap) begin c_wraps++; c_last = c_len; end
            end
            check("period5_wraps", a_wraps, 32'd9);
            check("period5_len", a_last, 32'd31);
            check("period8_wraps", c_wraps, 32'd1);
            check("period8_len", c_last, 32'd255);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
